// File: rtl/rand_seq_sched_pkg.sv
// Shared types and constants for the random-sequence scheduler.
//   state_e     : scheduler FSM states
//   SEQ_W_DEF   : default width of one random sequence
//   FILL_CYCLES : enabled edges the generator needs to produce one sequence
package rand_seq_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRestart,
    StFill,
    StDeliver
  } state_e;

  localparam int unsigned SEQ_W_DEF   = 288;
  localparam int unsigned FILL_CYCLES = 511;

endpackage

// File: rtl/rand_seq_sched_rr_arbiter.sv
// Combinational round-robin pick.
// The search starts at i_last_grant + 1 and wraps at NUM_REQ, so the
// requester granted last has the lowest priority.
// Ports:
//   i_req        : request vector
//   i_last_grant : index of the previous grant
//   o_grant      : chosen index (0 when no request is pending)
//   o_any        : at least one request bit is high
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic [ID_W-1:0]    o_grant,
  output logic               o_any
);

  logic [ID_W-1:0] w_idx;

  // Walk from the farthest offset to the nearest one, so the nearest
  // pending requester is the last to write and therefore wins.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      w_idx = ID_W'((32'(i_last_grant) + i) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_grant = w_idx;
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rand_seq_sched.sv
// Random-sequence scheduler.
// It shares one external random-sequence generator among NUM_REQ requesters.
// A granted requester gets one freshly generated sequence. Grants rotate
// round-robin. Every output is registered.
// Optional feature: with RAND_SEQ_SCHED_PREFETCH_EN defined, the generator is
// refilled in the background. A request is then served from the parked
// sequence one edge after it is sampled.
// Ports:
//   clk, reset          : clock; synchronous active-high reset
//   req                 : per-requester request level, held until served
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_seq     : granted requester and its sequence
//   gen_reset_n         : active-low restart pulse to the generator
//   gen_enable          : generator shift enable
//   gen_done, gen_seq   : generator completion flag and sequence
//   busy                : scheduler is not idle
module rand_seq_sched
  import rand_seq_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SEQ_W   = SEQ_W_DEF,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [SEQ_W-1:0]   rsp_seq,
  output logic               gen_reset_n,
  output logic               gen_enable,
  input  logic               gen_done,
  input  logic [SEQ_W-1:0]   gen_seq,
  output logic               busy
);

  state_e           r_state, w_state_d;
  logic [ID_W-1:0]  r_last_grant, w_last_grant_d;
  logic [ID_W-1:0]  r_rsp_id, w_rsp_id_d;
  logic [SEQ_W-1:0] r_rsp_seq, w_rsp_seq_d;
  logic             r_rsp_valid, w_rsp_valid_d;
  logic             r_gen_enable, w_gen_enable_d;
  logic             r_gen_reset_n, w_gen_reset_n_d;
  logic             r_busy;
  logic [ID_W-1:0]  w_grant;
  logic             w_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // The outputs are computed for the state being entered, so each one
  // changes on the same edge as the state.
  always_comb begin
    w_state_d       = r_state;
    w_last_grant_d  = r_last_grant;
    w_rsp_id_d      = r_rsp_id;
    w_rsp_seq_d     = r_rsp_seq;
    w_rsp_valid_d   = r_rsp_valid;
    w_gen_enable_d  = 1'b0;
    w_gen_reset_n_d = 1'b1;
    unique case (r_state)
      StIdle: begin
`ifdef RAND_SEQ_SCHED_PREFETCH_EN
        // An idle scheduler with no parked sequence starts a background fill.
        if (!gen_done) begin
          w_state_d       = StRestart;
          w_gen_reset_n_d = 1'b0;
        end else if (w_any) begin
          w_rsp_id_d    = w_grant;
          w_rsp_seq_d   = gen_seq;
          w_rsp_valid_d = 1'b1;
          w_state_d     = StDeliver;
        end
`else
        if (w_any) begin
          w_rsp_id_d      = w_grant;
          w_state_d       = StRestart;
          w_gen_reset_n_d = 1'b0;
        end
`endif
      end
      StRestart: begin
        w_state_d      = StFill;
        w_gen_enable_d = 1'b1;
      end
      StFill: begin
        if (gen_done) begin
`ifdef RAND_SEQ_SCHED_PREFETCH_EN
          // The generator stays parked with gen_done high until a request arrives.
          w_state_d     = StIdle;
`else
          w_rsp_seq_d   = gen_seq;
          w_rsp_valid_d = 1'b1;
          w_state_d     = StDeliver;
`endif
        end else begin
          w_gen_enable_d = 1'b1;
        end
      end
      StDeliver: begin
        if (rsp_ready) begin
          w_last_grant_d = r_rsp_id;
          w_rsp_valid_d  = 1'b0;
`ifdef RAND_SEQ_SCHED_PREFETCH_EN
          w_state_d       = StRestart;
          w_gen_reset_n_d = 1'b0;
`else
          w_state_d       = StIdle;
`endif
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Requester 0 wins the first arbitration after reset.
      r_last_grant  <= ID_W'(NUM_REQ - 1);
      r_rsp_id      <= '0;
      r_rsp_seq     <= '0;
      r_rsp_valid   <= 1'b0;
      r_gen_enable  <= 1'b0;
      r_gen_reset_n <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_last_grant  <= w_last_grant_d;
      r_rsp_id      <= w_rsp_id_d;
      r_rsp_seq     <= w_rsp_seq_d;
      r_rsp_valid   <= w_rsp_valid_d;
      r_gen_enable  <= w_gen_enable_d;
      r_gen_reset_n <= w_gen_reset_n_d;
      r_busy        <= (w_state_d != StIdle);
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_seq     = r_rsp_seq;
  assign gen_enable  = r_gen_enable;
  assign gen_reset_n = r_gen_reset_n;
  assign busy        = r_busy;

endmodule

// File: tb/tb_rand_seq_sched.sv
// Testbench for rand_seq_sched in its default build, where sequences are
// generated on demand. A behavioural generator supplies the sequences. A
// transaction-level model pushes the expected grants into a scoreboard, and a
// monitor checks every response against that scoreboard.
module tb_rand_seq_sched;

  localparam int N    = 4;
  localparam int IW   = $clog2(N);
  localparam int W    = 288;
  localparam int FILL = 511;
  localparam int LAT  = FILL + 2;  // grant edge to rsp_valid edge

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_id;
  logic [W-1:0]  rsp_seq;
  logic          gen_reset_n;
  logic          gen_enable;
  logic          gen_done;
  logic [W-1:0]  gen_seq;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rand_seq_sched #(
    .NUM_REQ (N),
    .SEQ_W   (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_seq     (rsp_seq),
    .gen_reset_n (gen_reset_n),
    .gen_enable  (gen_enable),
    .gen_done    (gen_done),
    .gen_seq     (gen_seq),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_seq();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // Generator: a fresh random sequence per restart, done after FILL enabled
  // edges. gen_seq shows junk while the generator is not done.
  logic [W-1:0] g_cur = '0;
  int           g_cnt = 0;
  always @(posedge clk) begin
    if (gen_reset_n !== 1'b1) begin
      g_cnt <= 0;
      g_cur <= rand_seq();
    end else if (gen_enable && g_cnt < FILL) begin
      g_cnt <= g_cnt + 1;
    end
  end
  assign gen_done = (g_cnt == FILL);
  assign gen_seq  = gen_done ? g_cur : ~g_cur;

  // Reference model at the transaction level. Phases: 0 idle, 1 generating, 2 delivering.
  typedef struct packed { int id; int due; } exp_t;
  exp_t sb[$];
  int   cyc    = 0;
  int   m_st   = 0;
  int   m_last = N - 1;
  int   m_id   = 0;
  int   m_due  = 0;
  int   e_idx;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    logic [IW-1:0] j;
    for (int k = 1; k <= N; k++) begin
      j = IW'((last + k) % N);
      if (r[j]) return int'(j);
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    e_idx = cyc + 1;
    cyc <= cyc + 1;
    if (reset) begin
      m_st   = 0;
      m_last = N - 1;
      sb.delete();
    end else begin
      case (m_st)
        0: if (req != '0) begin
          m_id  = rr_pick(req, m_last);
          m_due = e_idx + LAT;
          sb.push_back('{id: m_id, due: m_due});
          m_st  = 1;
        end
        1: if (e_idx == m_due) m_st = 2;
        default: if (rsp_ready) begin
          m_last = m_id;
          m_st   = 0;
        end
      endcase
    end
  end

  // Monitor: sample between edges and pop one expectation per new delivery.
  bit           in_del = 1'b0;
  int           exp_id = 0;
  logic [W-1:0] exp_seq = '0;
  exp_t         ent;
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy", W'(busy), W'(m_st != 0));
      check("rsp_valid", W'(rsp_valid), W'(m_st == 2));
      if (reset) begin
        in_del = 1'b0;
      end else if (rsp_valid) begin
        if (!in_del) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got id %0d want no response", rsp_id);
          end else begin
            ent     = sb.pop_front();
            exp_id  = ent.id;
            exp_seq = g_cur;
            check("rsp_id", W'(rsp_id), W'(exp_id));
            check("latency_edge", W'(cyc), W'(ent.due));
            check("rsp_seq", rsp_seq, exp_seq);
          end
          in_del = 1'b1;
        end else begin
          check("rsp_id_stable", W'(rsp_id), W'(exp_id));
          check("rsp_seq_stable", rsp_seq, exp_seq);
        end
        if (rsp_ready) in_del = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a transfer. Optionally randomise rsp_ready and optionally
  // drop the served request bit. Returns the served id, or -1 on timeout.
  task automatic wait_xfer(input bit rnd, input bit drop, output int id);
    bit got = 1'b0;
    id = -1;
    for (int k = 0; k < 2000 && !got; k++) begin
      step();
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        got = 1'b1;
        id  = int'(rsp_id);
      end
    end
    if (got) begin
      step();
      if (drop) req[IW'(id)] = 1'b0;
    end else begin
      total++;
      bad++;
      $display("FAIL xfer_timeout: got no transfer want one within 2000 cycles");
    end
  endtask

  task automatic wait_sig(input string name, input bit use_valid);
    bit got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      got = use_valid ? rsp_valid : gen_enable;
    end
    check(name, W'(got), W'(1));
  endtask

  int id;
  int exp_ids[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1;
    req = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_rsp_id", W'(rsp_id), W'(0));
    check("rst_rsp_seq", rsp_seq, W'(0));
    check("rst_gen_enable", W'(gen_enable), W'(0));
    check("rst_gen_reset_n", W'(gen_reset_n), W'(0));
    check("rst_busy", W'(busy), W'(0));
    step();
    reset = 1'b0;

    // Single requester: one-cycle restart pulse, then the fill enable.
    rsp_ready = 1'b1;
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check("restart_gen_reset_n", W'(gen_reset_n), W'(0));
    check("restart_gen_enable", W'(gen_enable), W'(0));
    @(negedge clk);
    check("fill_gen_reset_n", W'(gen_reset_n), W'(1));
    check("fill_gen_enable", W'(gen_enable), W'(1));
    wait_xfer(1'b0, 1'b1, id);
    check("single_id", W'(id), W'(0));

    // All requesters held: strict rotation from requester 0.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_xfer(1'b0, 1'b0, id);
      check("rotation_id", W'(id), W'(exp_ids[t]));
    end
    req = '0;

    // Consumer stalls for 20 cycles in deliver.
    rsp_ready = 1'b0;
    req = 4'b0100;
    wait_sig("stall_valid_seen", 1'b1);
    repeat (20) begin
      @(negedge clk);
      check("stall_valid", W'(rsp_valid), W'(1));
      check("stall_id", W'(rsp_id), W'(2));
    end
    step();
    rsp_ready = 1'b1;
    step();
    req = '0;
    @(negedge clk);
    check("post_xfer_valid", W'(rsp_valid), W'(0));
    check("post_xfer_busy", W'(busy), W'(0));

    // Reset 100 cycles into the fill, then a full-latency restart.
    req = 4'b0010;
    wait_sig("fill_seen", 1'b0);
    repeat (100) step();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", W'(rsp_valid), W'(0));
    check("midrst_gen_enable", W'(gen_enable), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    step();
    reset = 1'b0;
    wait_xfer(1'b0, 1'b1, id);
    check("midrst_id", W'(id), W'(1));

    // A request dropped during the fill is still delivered.
    req = 4'b0100;
    wait_sig("fill2_seen", 1'b0);
    repeat (50) step();
    req = '0;
    wait_xfer(1'b0, 1'b0, id);
    check("dropped_req_id", W'(id), W'(2));

    // Random request sets with a random consumer.
    for (int r = 0; r < 4; r++) begin
      step();
      req = N'($urandom_range(1, (1 << N) - 1));
      for (int g = 0; g < N && req != '0; g++) wait_xfer(1'b1, 1'b1, id);
      check("random_round_drained", W'(req), W'(0));
    end

    repeat (5) step();
    check("scoreboard_empty", W'(sb.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
